// File: rtl/seq_cmp_pkg.sv
// ============================================================================
// Module      : seq_cmp_pkg
// Description : Shared types and helpers for the sequential magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_cmp_pkg;

    localparam int unsigned C_STATE_W = 2;

    typedef enum logic [C_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_result_t;

    function automatic int seq_cmp_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_chunk.sv
// ============================================================================
// Module      : cmp_chunk
// Description : Combinational unsigned compare of two CHUNK-bit slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

`default_nettype wire

// File: rtl/seq_comparator.sv
// ============================================================================
// Module      : seq_comparator
// Description : Multi-cycle signed/unsigned magnitude comparator, MSB chunk first.
//               Define SEQ_CMP_EARLY_EXIT_EN to stop at the first differing chunk;
//               otherwise every compare takes exactly NCHUNK scan cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_comparator
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_gt,
    output logic             out_lt,
    output logic             out_eq,
    output logic             busy
);

    localparam int NCHUNK = seq_cmp_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] w_flip;
    logic [IDX_W-1:0] r_idx;
    cmp_result_t      r_res;
    cmp_result_t      w_chunk_res;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_cgt;
    logic             w_clt;
    logic             w_ceq;
    logic             w_last;
`ifndef SEQ_CMP_EARLY_EXIT_EN
    cmp_result_t      r_pend;
    logic             r_decided;
`endif

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        w_flip            = '0;
        w_flip[WIDTH-1]   = is_signed;
    end

    assign w_ca        = r_a[r_idx*CHUNK +: CHUNK];
    assign w_cb        = r_b[r_idx*CHUNK +: CHUNK];
    assign w_last      = (r_idx == '0);
    assign w_chunk_res = '{gt: w_cgt, lt: w_clt, eq: w_ceq};

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .i_a  (w_ca),
        .i_b  (w_cb),
        .o_gt (w_cgt),
        .o_lt (w_clt),
        .o_eq (w_ceq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = ST_SCAN;
`ifdef SEQ_CMP_EARLY_EXIT_EN
            ST_SCAN: if (w_cgt || w_clt || w_last) w_next_state = ST_DONE;
`else
            ST_SCAN: if (w_last) w_next_state = ST_DONE;
`endif
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_res     <= '0;
`ifndef SEQ_CMP_EARLY_EXIT_EN
            r_pend    <= '0;
            r_decided <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a ^ w_flip;
                        r_b   <= b ^ w_flip;
                        r_idx <= C_IDX_LAST;
`ifndef SEQ_CMP_EARLY_EXIT_EN
                        r_decided <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                    if (w_cgt || w_clt || w_last) begin
                        r_res <= w_chunk_res;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
`else
                    // The first differing chunk is parked in r_pend so outputs only move at the end.
                    if (w_last) begin
                        r_res <= r_decided ? r_pend : w_chunk_res;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                        if (!r_decided && !w_ceq) begin
                            r_pend    <= w_chunk_res;
                            r_decided <= 1'b1;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        busy      = (r_state != ST_IDLE);
        out_gt    = r_res.gt;
        out_lt    = r_res.lt;
        out_eq    = r_res.eq;
    end

endmodule

`default_nettype wire
